scale_iter_n: RTL and testbench

Parametrised iterative range reducer. Accepts an IN_W-bit unsigned word over a valid/ready handshake and right-shifts it by STEP bits per clock until it fits in OUT_W bits. It then presents the reduced value together with the total shift applied, so downstream logic can treat the pair as mantissa/exponent. It sits between wide accumulators and narrow display/DAC paths, and generalises the fixed 32→16, shift-by-2 scaler with configurable widths, step, handshaking and optional rounding.

---
 rtl/scale_pkg.sv | 10 +
 rtl/scale_rnd_sat.sv | 17 +
 rtl/scale_iter_n.sv | 99 +++++++++
 tb/tb_scale_iter_n.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// scale_pkg: shared state encoding and fit test for the scaler family
package scale_pkg;
  localparam int MAX_W = 64;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} scale_state_e;
  // True when no bit at or above out_w is set, i.e. acc fits in out_w bits.
  // Callers zero-extend their accumulator to MAX_W bits.
  function automatic logic fit_chk(input logic [MAX_W-1:0] acc, input int out_w);
    return (acc >> out_w) == '0;
  endfunction
endpackage

// File: rtl/scale_rnd_sat.sv
// scale_rnd_sat: adds the round bit to a value and saturates at all ones
//   val_i [OUT_W]  truncated value
//   rnd_i          round bit (MSB shifted out)
//   y_o   [OUT_W]  rounded, saturated value
module scale_rnd_sat #(
  parameter int OUT_W = 16
) (
  input  logic [OUT_W-1:0] val_i,
  input  logic             rnd_i,
  output logic [OUT_W-1:0] y_o
);
  logic [OUT_W:0] sum;
  always_comb begin
    sum = {1'b0, val_i} + {{OUT_W{1'b0}}, rnd_i};
    y_o = sum[OUT_W] ? '1 : sum[OUT_W-1:0];
  end
endmodule

// File: rtl/scale_iter_n.sv
// scale_iter_n: iterative right-shift range reducer (IN_W -> OUT_W bits, STEP bits per clock)
//   clk_i, rst_i (async, active low)
//   valid_i/data_i/ready_o  input word handshake
//   valid_o/y_o/shift_o/ready_i  result handshake (mantissa y_o, exponent shift_o)
//   SCALE_ROUND_EN: when defined, round half-up with saturation; otherwise truncate.
//   IN_W is limited to scale_pkg::MAX_W.
module scale_iter_n
  import scale_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16,
  parameter int STEP  = 2,
  parameter int SH_W  = $clog2(IN_W + STEP + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [IN_W-1:0]  data_i,
  output logic             ready_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [OUT_W-1:0] y_o,
  output logic [SH_W-1:0]  shift_o
);
  scale_state_e state_q, state_d;
  logic [IN_W-1:0] acc_q, acc_d;
  logic [SH_W-1:0] cnt_q, cnt_d, shift_q, shift_d;
  logic [OUT_W-1:0] y_q, y_d, res;
  logic fit;
`ifdef SCALE_ROUND_EN
  logic rnd_q, rnd_d;
  scale_rnd_sat #(.OUT_W(OUT_W)) u_rnd (
    .val_i(acc_q[OUT_W-1:0]),
    .rnd_i(rnd_q),
    .y_o  (res)
  );
`else
  assign res = acc_q[OUT_W-1:0];
`endif
  assign fit     = fit_chk(MAX_W'(acc_q), OUT_W);
  assign ready_o = state_q == S_IDLE;
  assign valid_o = state_q == S_DONE;
  assign y_o     = y_q;
  assign shift_o = shift_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    shift_d = shift_q;
`ifdef SCALE_ROUND_EN
    rnd_d   = rnd_q;
`endif
    case (state_q)
      S_IDLE: if (valid_i) begin
        state_d = S_SHIFT;
        acc_d   = data_i;
        cnt_d   = '0;
`ifdef SCALE_ROUND_EN
        rnd_d   = 1'b0;
`endif
      end
      S_SHIFT: if (fit) begin
        state_d = S_DONE;
        y_d     = res;
        shift_d = cnt_q;
      end else begin
        acc_d = acc_q >> STEP;
        cnt_d = cnt_q + SH_W'(STEP);
`ifdef SCALE_ROUND_EN
        rnd_d = acc_q[STEP-1];
`endif
      end
      S_DONE: if (ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      shift_q <= '0;
`ifdef SCALE_ROUND_EN
      rnd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      shift_q <= shift_d;
`ifdef SCALE_ROUND_EN
      rnd_q   <= rnd_d;
`endif
    end
  end
endmodule

// File: tb/tb_scale_iter_n.sv
// tb_scale_iter_n: scoreboard bench for scale_iter_n (default and OUT_W=8/STEP=3 instances)
module tb_scale_iter_n;
`ifdef SCALE_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  typedef struct {
    int          d;
    logic [15:0] y;
    logic [5:0]  sh;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vi[2] = '{1'b0, 1'b0};
  logic [31:0] di[2] = '{32'd0, 32'd0};
  logic        ri[2] = '{1'b0, 1'b0};
  logic        ro[2];
  logic        vo[2];
  logic [15:0] y0;
  logic [7:0]  y1;
  logic [5:0]  sh0, sh1;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur[2];
  bit   busy[2] = '{1'b0, 1'b0};
  int   hold[2] = '{0, 0};

  scale_iter_n u_dut0 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(vi[0]), .data_i(di[0]), .ready_o(ro[0]),
    .valid_o(vo[0]), .ready_i(ri[0]), .y_o(y0), .shift_o(sh0)
  );
  scale_iter_n #(.IN_W(32), .OUT_W(8), .STEP(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst_n), .valid_i(vi[1]), .data_i(di[1]), .ready_o(ro[1]),
    .valid_o(vo[1]), .ready_i(ri[1]), .y_o(y1), .shift_o(sh1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint got, input longint req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, req);
    end
  endtask

  // Reference: repeatedly divide by 2^STEP until the value fits, count the steps.
  function automatic exp_t model(input int d, input logic [31:0] x);
    exp_t   e;
    int     ow = d ? 8 : 16;
    int     st = d ? 3 : 2;
    longint lim = longint'(1) << ow;
    longint v = longint'(x);
    int     k = 0;
    while (v >= lim) begin
      v = v / (longint'(1) << st);
      k++;
    end
    if (RND && k > 0) begin
      v = v + ((longint'(x) >> (k * st - 1)) & 1);
      if (v >= lim) v = lim - 1;
    end
    e.d = d;
    e.y = 16'(v);
    e.sh = 6'(k * st);
    e.due = k + 1;
    return e;
  endfunction

  task automatic mon(input int d, input logic v, input logic r, input logic [15:0] y, input logic [5:0] sh);
    exp_t e;
    bit   infl;
    infl = busy[d] || (q.size() > 0 && q[0].d == d);
    chk($sformatf("ready_o%0d", d), longint'(r), longint'(!infl));
    if (v && !busy[d]) begin
      if (q.size() == 0 || q[0].d != d) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid%0d: valid_o=1 required 0", d);
      end else begin
        e = q.pop_front();
        chk($sformatf("y_o%0d", d), longint'(y), longint'(e.y));
        chk($sformatf("shift_o%0d", d), longint'(sh), longint'(e.sh));
        chk($sformatf("latency%0d", d), longint'(cyc), longint'(e.due));
        cur[d] = e;
        busy[d] = 1'b1;
      end
    end else if (v) begin
      chk($sformatf("y_hold%0d", d), longint'(y), longint'(cur[d].y));
      chk($sformatf("shift_hold%0d", d), longint'(sh), longint'(cur[d].sh));
    end
    if (v) begin
      if (hold[d] > 0) begin
        hold[d]--;
        ri[d] = 1'b0;
      end else ri[d] = $urandom_range(0, 3) != 0;
      if (ri[d]) busy[d] = 1'b0;
    end else begin
      busy[d] = 1'b0;
      ri[d] = 1'($urandom_range(0, 1));
    end
  endtask

  always @(negedge clk) begin
    mon(0, vo[0], ro[0], y0, sh0);
    mon(1, vo[1], ro[1], {8'd0, y1}, sh1);
  end

  task automatic send(input int d, input logic [31:0] x, input bit churn);
    exp_t e;
    int   n;
    @(negedge clk);
    vi[d] = 1'b1;
    di[d] = x;
    n = 0;
    while (!ro[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!ro[d]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout%0d: ready_o=0 required 1", d);
      vi[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e = model(d, x);
    e.due = cyc + e.due;
    q.push_back(e);
    if (churn) begin
      n = 0;
      do begin
        @(negedge clk);
        if (!ro[d]) di[d] = $urandom;
        n++;
      end while (!ro[d] && n < 300);
    end
    vi[d] = 1'b0;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_valid_o", longint'(vo[0]), 0);
    chk("rst_y_o", longint'(y0), 0);
    chk("rst_shift_o", longint'(sh0), 0);
    chk("rst_ready_o", longint'(ro[0]), 1);
    rst_n = 1'b1;
    send(0, 32'h0000_1234, 1'b0);
    send(0, 32'hFFFF_FFFF, 1'b0);
    send(0, 32'h0002_FFFE, 1'b0);
    send(0, 32'h0000_0000, 1'b0);
    send(0, 32'h0000_FFFF, 1'b0);
    send(0, 32'h0001_0000, 1'b1);
    // Reset in the middle of an 8-step word
    send(0, 32'hFFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_valid_o", longint'(vo[0]), 0);
    chk("midrst_y_o", longint'(y0), 0);
    chk("midrst_shift_o", longint'(sh0), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready_o", longint'(ro[0]), 1);
    send(0, 32'h0002_FFFE, 1'b0);
    repeat (40) send(0, $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    hold[1] = 5;
    send(1, 32'h0000_0800, 1'b0);
    send(1, 32'h0000_00FF, 1'b0);
    send(1, 32'hFFFF_FFFF, 1'b1);
    repeat (20) send(1, $urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    n = 0;
    while ((q.size() > 0 || busy[0] || busy[1]) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain", longint'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
